rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter that sits directly upstream of the 4-to-1 bus multiplexer.
- It decides which of four sources owns the shared single-bit bus path and drives the multiplexer's 2-bit select.
- It also provides a one-hot grant back to the requesters, with an optional hold-time limit so no source can starve the others.
- All outputs are registered, so the mux select is glitch-free.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles a grant may be held; 0 disables the limit.
- CNT_W, 4: hold counter width; must satisfy 2^CNT_W > MAX_HOLD, minimum 1.

Ports:
- sysclk  input  1  system clock; all state changes on rising edge.
- sys_rst  input  1  asynchronous, active-high reset.
- req  input  4  request lines; bit i = source i. Level-sensitive; held high for as long as ownership is wanted.
- gnt  output  4  one-hot grant, registered. All zero when nobody owns the bus.
- sel  output  2  binary index of the current or last owner; drives the multiplexer select, registered.
- busy  output  1  high while state is GRANT.
- preempt  output  1  one-cycle pulse when a grant is forcibly ended by MAX_HOLD.

Behaviour:
- Reset: one clock, asynchronous active-high reset.
  - On sys_rst high, immediately and independent of sysclk: gnt=4'b0000, sel=2'b00, busy=0, preempt=0, state=IDLE, last=2'd3, hold_cnt=0.
  - Reset asserted mid-grant drops gnt in the same cycle, with no TURN cycle.
  - First arbitration after reset release favours req[0].
- States: IDLE, GRANT, TURN.
- Arbitration occurs at a rising edge when state is IDLE or TURN.
  - Priority order starts at (last+1) mod 4 and wraps: e.g. last=1 gives order 2,3,0,1.
  - Winner w: at that edge gnt<=1<<w, sel<=w, owner<=w, hold_cnt<=0, state<=GRANT.
  - No req bits set: remain/go IDLE with gnt=0.
- Latency: req sampled at edge E in IDLE gives gnt visible after E (one edge).
- GRANT:
  - Normal hold: req[owner]=1 and (MAX_HOLD=0 or hold_cnt<MAX_HOLD-1) → stay; hold_cnt increments, saturating at the counter maximum when MAX_HOLD=0.
  - Release: req[owner]=0 at an edge → gnt<=0, last<=owner, state<=TURN; preempt stays 0.
  - Forced release: req[owner]=1 and MAX_HOLD>0 and hold_cnt==MAX_HOLD-1 → same as release, but preempt<=1 for exactly one cycle. The owner is granted exactly MAX_HOLD cycles.
  - Other req bits changing during GRANT have no effect.
- TURN:
  - Exactly one dead cycle with gnt=0 and busy=0.
  - Arbitrates at its closing edge.
  - A preempted owner that keeps req high competes with lowest priority.
- sel is only updated on a new grant; it holds the last owner through TURN and IDLE so the mux output stays stable.
- Invariants:
  - gnt is never more than one-hot.
  - gnt!=0 implies sel equals the index of the set bit and busy=1.
- Same-edge events: owner drop and another request at the same edge → TURN first; the new grant comes one cycle later (no back-to-back grants).

Test Plan:
1. Reset mid-grant: owner 2 granted, assert sys_rst between edges → gnt=0000, sel=00, busy=0 before the next edge. Release, then req=1111 → after one edge gnt=0001, sel=00.
2. Round-robin rotation (MAX_HOLD=0): req=1111 continuously, owner drops its req for one cycle at a time → grants in order 0,1,2,3,0. Each gnt is separated by one zero cycle; sel follows 0,1,2,3,0.
3. Single requester: req=0100 only → gnt=0100, sel=10 after one edge. Drop req → gnt=0000 next cycle, sel stays 10, state IDLE after TURN.
4. Hold limit (MAX_HOLD=4): req=0010 held → gnt=0010 for exactly 4 cycles, then preempt=1 for one cycle with gnt=0000. Then gnt=0010 again, since there is no competitor.
5. Preempted fairness (MAX_HOLD=4): req=0011, owner 0 held → after 4 cycles plus TURN, gnt=0010 (source 1), not source 0.
6. Wrap-around: last=3, req=1001 → next grant is 0001; then with last=0 and req=1001 → next grant is 1000.

Source files
------------

// File: rtl/rr_arbiter_4_if.sv
// Requester-side bus of the 4-way round-robin arbiter.
// The master drives requests; the slave (arbiter) returns grant, mux select and status.
interface rr_arbiter_4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       preempt;

  modport master (output req, input gnt, sel, busy, preempt);
  modport slave  (input req, output gnt, sel, busy, preempt);
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter feeding a 4:1 bus mux select.
// Registered outputs, one dead TURN cycle between owners, optional hold limit.
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input logic          sysclk,
  input logic          sys_rst,
  rr_arbiter_4_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} stateT;

  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;

  stateT            state;
  logic [1:0]       last;
  logic [1:0]       owner;
  logic [CNT_W-1:0] holdCnt;

  logic [1:0] winIdx;
  logic       winFound;
  logic [1:0] cand;

  // Search starts one past the last owner, so a preempted source ends up lowest priority.
  always_comb begin
    winIdx   = '0;
    winFound = 1'b0;
    cand     = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!winFound && bus.req[cand]) begin
        winIdx   = cand;
        winFound = 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      last        <= 2'd3;
      owner       <= '0;
      holdCnt     <= '0;
      bus.gnt     <= '0;
      bus.sel     <= '0;
      bus.busy    <= 1'b0;
      bus.preempt <= 1'b0;
    end else begin
      bus.preempt <= 1'b0;
      case (state)
        IDLE, TURN: begin
          if (winFound) begin
            bus.gnt  <= 4'b0001 << winIdx;
            bus.sel  <= winIdx;
            owner    <= winIdx;
            holdCnt  <= '0;
            bus.busy <= 1'b1;
            state    <= GRANT;
          end else begin
            bus.gnt  <= '0;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        GRANT: begin
          if (!bus.req[owner] || (MAX_HOLD != 0 && holdCnt == HOLD_LAST)) begin
            bus.gnt     <= '0;
            bus.busy    <= 1'b0;
            last        <= owner;
            bus.preempt <= bus.req[owner];
            state       <= TURN;
          end else if (holdCnt != '1) begin
            holdCnt <= holdCnt + 1'b1;
          end
        end
        default: begin
          bus.gnt  <= '0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed-vector bench for rr_arbiter_4: unlimited-hold and MAX_HOLD=4 instances,
// expected outputs queued by the driver and compared by an independent monitor.
module tb_rr_arbiter_4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_arbiter_4_if if0 ();
  rr_arbiter_4_if if4 ();

  rr_arbiter_4 #(.MAX_HOLD(0), .CNT_W(4)) dut0 (.sysclk(clk), .sys_rst(rst), .bus(if0.slave));
  rr_arbiter_4 #(.MAX_HOLD(4), .CNT_W(4)) dut4 (.sysclk(clk), .sys_rst(rst), .bus(if4.slave));

  typedef struct {
    int unsigned dutId;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        busy;
    logic        pre;
    string       name;
  } expT;

  expT expQ[$];
  int  checks = 0;
  int  errors = 0;

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushExp(input int unsigned d, input logic [3:0] g, input logic [1:0] s,
                         input logic b, input logic p, input string name);
    expT e;
    e.dutId = d; e.gnt = g; e.sel = s; e.busy = b; e.pre = p; e.name = name;
    expQ.push_back(e);
  endtask

  // Drive one request vector before the coming edge and queue what must follow it.
  task automatic step(input int unsigned d, input logic [3:0] r, input logic [3:0] g,
                      input logic [1:0] s, input logic b, input logic p, input string name);
    if (d == 0) if0.req = r; else if4.req = r;
    pushExp(d, g, s, b, p, name);
    @(negedge clk);
    #1;
  endtask

  // Monitor: outputs settle between edges; compare at every falling edge.
  expT cur;
  logic [3:0] aGnt;
  logic [1:0] aSel;
  logic       aBusy, aPre;
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      cur   = expQ.pop_front();
      aGnt  = (cur.dutId == 0) ? if0.gnt     : if4.gnt;
      aSel  = (cur.dutId == 0) ? if0.sel     : if4.sel;
      aBusy = (cur.dutId == 0) ? if0.busy    : if4.busy;
      aPre  = (cur.dutId == 0) ? if0.preempt : if4.preempt;
      cmp({cur.name, ".gnt"},  aGnt, cur.gnt);
      cmp({cur.name, ".sel"},  {2'b00, aSel}, {2'b00, cur.sel});
      cmp({cur.name, ".busy"}, {3'b000, aBusy}, {3'b000, cur.busy});
      cmp({cur.name, ".pre"},  {3'b000, aPre}, {3'b000, cur.pre});
    end
    if (if0.gnt != 4'b0000)
      cmp("inv0.sel", {2'b00, if0.sel}, {2'b00, (if0.gnt[1] | if0.gnt[3]), (if0.gnt[2] | if0.gnt[3])} & 4'b0000 | {2'b00, {if0.gnt[2] | if0.gnt[3], if0.gnt[1] | if0.gnt[3]}});
    if (if4.gnt != 4'b0000)
      cmp("inv4.onehot", {3'b000, $onehot(if4.gnt)}, 4'b0001);
  end

  initial begin
    if0.req = '0;
    if4.req = '0;
    @(negedge clk);
    #1;
    step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "reset0");
    step(1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "reset4");
    rst = 1'b0;

    // single requester, then idle with sel held
    step(0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "single.grant");
    step(0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "single.turn");
    step(0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "single.idle");

    // reset asserted mid-grant, between edges
    step(0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "midrst.grant");
    @(posedge clk);
    #1;
    rst = 1'b1;
    pushExp(0, 4'b0000, 2'd0, 1'b0, 1'b0, "midrst.async");
    @(negedge clk);
    #1;
    rst = 1'b0;
    step(0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0, "midrst.first");

    // rotation with unlimited hold
    step(0, 4'b1110, 4'b0000, 2'd0, 1'b0, 1'b0, "rot.t0");
    step(0, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0, "rot.g1");
    step(0, 4'b1101, 4'b0000, 2'd1, 1'b0, 1'b0, "rot.t1");
    step(0, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0, "rot.g2");
    step(0, 4'b1011, 4'b0000, 2'd2, 1'b0, 1'b0, "rot.t2");
    step(0, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0, "rot.g3");
    step(0, 4'b0111, 4'b0000, 2'd3, 1'b0, 1'b0, "rot.t3");
    step(0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0, "rot.g0");
    for (int i = 0; i < 10; i++)
      step(0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0, "rot.nolimit");
    step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rot.turn");
    step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rot.idle");

    // wrap-around from last=3 and last=0
    step(1, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0, "wrap.g0");
    step(1, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0, "wrap.t0");
    step(1, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0, "wrap.g3");
    step(1, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, "wrap.t3");
    step(1, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, "wrap.idle");

    // hold limit with no competitor
    for (int i = 0; i < 4; i++)
      step(1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, "hold.grant");
    step(1, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b1, "hold.preempt");
    step(1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, "hold.regrant");
    step(1, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "hold.turn");
    step(1, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "hold.idle");

    // preempted owner yields to the waiting source
    for (int i = 0; i < 4; i++)
      step(1, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0, "fair.grant0");
    step(1, 4'b0011, 4'b0000, 2'd0, 1'b0, 1'b1, "fair.preempt");
    step(1, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0, "fair.grant1");
    step(1, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "fair.turn");
    step(1, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "fair.idle");

    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, required finish before 100000");
    $fatal(1);
  end

endmodule
